// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and MEM stage share one
// single-cycle RAM port. MEM has priority; a saturating counter bounds IF starvation.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        mem_req,
    input  logic [1:0]  mem_ctrl,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ram_addr,
    output logic [1:0]  ram_ctrl,
    output logic [15:0] ram_wdata,
    output logic [15:0] if_rdata,
    output logic [15:0] mem_rdata,
    output logic        if_done,
    output logic        mem_done,
    output logic        if_stall,
    output logic        mem_stall,
    output logic [1:0]  fsm_state,
    output logic [1:0]  starve_cnt
);

    // Handshake: a requester raises req and holds it (with stable address/data)
    // until it sees a one-cycle done pulse; the arbiter never grants in that done cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    localparam logic [1:0] CTRL_NONE  = 2'b00;
    localparam logic [1:0] CTRL_READ  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b10;
    localparam logic [1:0] LIMIT      = 2'(STARVE_LIMIT);

    state_t state_q, state_d;
    logic   mem_valid;
    logic   grant_if, grant_mem;

    assign mem_valid = mem_req && (mem_ctrl == CTRL_READ || mem_ctrl == CTRL_WRITE);
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;
    assign fsm_state = state_q;

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        case (state_q)
            IDLE: begin
                // The cycle carrying a done pulse is a dead cycle for arbitration.
                if (!(if_done || mem_done)) begin
                    if (if_req && starve_cnt == LIMIT) begin
                        grant_if = 1'b1;
                    end else if (mem_valid) begin
                        grant_mem = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end
                end
                if (grant_if) begin
                    state_d = BUSY_IF;
                end else if (grant_mem) begin
                    state_d = BUSY_MEM;
                end
            end
            BUSY_IF:  state_d = IDLE;
            BUSY_MEM: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr   <= '0;
            ram_ctrl   <= CTRL_NONE;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (grant_if) begin
                ram_addr   <= if_addr;
                ram_ctrl   <= CTRL_READ;
                ram_wdata  <= '0;
                starve_cnt <= '0;
            end else if (grant_mem) begin
                ram_addr  <= mem_addr;
                ram_ctrl  <= mem_ctrl;
                ram_wdata <= mem_wdata;
                if (if_req && starve_cnt < LIMIT) begin
                    starve_cnt <= starve_cnt + 2'd1;
                end
            end
            if (state_q == BUSY_IF) begin
                if (ram_ctrl == CTRL_READ) begin
                    if_rdata <= ram_rdata;
                end
                if_done  <= 1'b1;
                ram_ctrl <= CTRL_NONE;
            end
            if (state_q == BUSY_MEM) begin
                if (ram_ctrl == CTRL_READ) begin
                    mem_rdata <= ram_rdata;
                end
                mem_done <= 1'b1;
                ram_ctrl <= CTRL_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single IF read, MEM-first priority, starvation
// escape, asynchronous reset mid-access and invalid MEM control.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        mem_req;
    logic [1:0]  mem_ctrl;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] ram_addr;
    logic [1:0]  ram_ctrl;
    logic [15:0] ram_wdata;
    logic [15:0] if_rdata;
    logic [15:0] mem_rdata;
    logic        if_done;
    logic        mem_done;
    logic        if_stall;
    logic        mem_stall;
    logic [1:0]  fsm_state;
    logic [1:0]  starve_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_starve [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0};

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .mem_req    (mem_req),
        .mem_ctrl   (mem_ctrl),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .ram_rdata  (ram_rdata),
        .ram_addr   (ram_addr),
        .ram_ctrl   (ram_ctrl),
        .ram_wdata  (ram_wdata),
        .if_rdata   (if_rdata),
        .mem_rdata  (mem_rdata),
        .if_done    (if_done),
        .mem_done   (mem_done),
        .if_stall   (if_stall),
        .mem_stall  (mem_stall),
        .fsm_state  (fsm_state),
        .starve_cnt (starve_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          waits;
        logic        got_grant;
        logic        exp_if;

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 16'h0;
        mem_req   = 1'b0;
        mem_ctrl  = 2'b00;
        mem_addr  = 16'h0;
        mem_wdata = 16'h0;
        ram_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 16'(fsm_state), 16'd0);
        check("rst_ram_addr", ram_addr, 16'h0);
        check("rst_ram_ctrl", 16'(ram_ctrl), 16'd0);
        check("rst_ram_wdata", ram_wdata, 16'h0);
        check("rst_if_rdata", if_rdata, 16'h0);
        check("rst_mem_rdata", mem_rdata, 16'h0);
        check("rst_dones", 16'({if_done, mem_done}), 16'd0);
        check("rst_starve", 16'(starve_cnt), 16'd0);
        rst = 1'b1;

        // IF read alone
        if_req    = 1'b1;
        if_addr   = 16'h0040;
        ram_rdata = 16'h1234;
        step();
        check("if_grant_addr", ram_addr, 16'h0040);
        check("if_grant_ctrl", 16'(ram_ctrl), 16'd1);
        check("if_grant_state", 16'(fsm_state), 16'd1);
        check("if_grant_nodone", 16'(if_done), 16'd0);
        check("if_grant_stall", 16'(if_stall), 16'd1);
        step();
        check("if_done_pulse", 16'(if_done), 16'd1);
        check("if_rdata", if_rdata, 16'h1234);
        check("if_done_ctrl", 16'(ram_ctrl), 16'd0);
        check("if_done_stall", 16'(if_stall), 16'd0);
        if_req = 1'b0;
        step();
        check("if_after_done", 16'(if_done), 16'd0);
        check("if_after_state", 16'(fsm_state), 16'd0);

        // simultaneous: MEM write first, IF at the next grant slot
        if_req    = 1'b1;
        if_addr   = 16'h0200;
        mem_req   = 1'b1;
        mem_ctrl  = 2'b10;
        mem_addr  = 16'h0100;
        mem_wdata = 16'hBEEF;
        ram_rdata = 16'h5555;
        step();
        check("sim_mem_ctrl", 16'(ram_ctrl), 16'd2);
        check("sim_mem_addr", ram_addr, 16'h0100);
        check("sim_mem_wdata", ram_wdata, 16'hBEEF);
        check("sim_if_stall0", 16'(if_stall), 16'd1);
        check("sim_starve1", 16'(starve_cnt), 16'd1);
        step();
        check("sim_mem_done", 16'(mem_done), 16'd1);
        check("sim_write_keeps_rdata", mem_rdata, 16'h0);
        check("sim_mem_stall", 16'(mem_stall), 16'd0);
        check("sim_if_stall1", 16'(if_stall), 16'd1);
        mem_req = 1'b0;
        step();
        check("sim_dead_cycle_ctrl", 16'(ram_ctrl), 16'd0);
        check("sim_if_stall2", 16'(if_stall), 16'd1);
        step();
        check("sim_if_ctrl", 16'(ram_ctrl), 16'd1);
        check("sim_if_addr", ram_addr, 16'h0200);
        check("sim_if_wdata", ram_wdata, 16'h0);
        check("sim_starve_clr", 16'(starve_cnt), 16'd0);
        ram_rdata = 16'hCAFE;
        step();
        check("sim_if_done", 16'(if_done), 16'd1);
        check("sim_if_rdata", if_rdata, 16'hCAFE);
        if_req = 1'b0;
        step();

        // starvation: IF held against back-to-back MEM reads
        if_req   = 1'b1;
        if_addr  = 16'h0300;
        mem_req  = 1'b1;
        mem_ctrl = 2'b01;
        mem_addr = 16'h0010;
        for (int g = 0; g < 5; g++) begin
            exp_if    = (g == 3);
            got_grant = 1'b0;
            waits     = 0;
            while (!got_grant && waits < 8) begin
                step();
                waits++;
                if (ram_ctrl != 2'b00) got_grant = 1'b1;
            end
            check("star_grant_seen", 16'(got_grant), 16'd1);
            check("star_grant_gap", 16'(waits), (g == 0) ? 16'd1 : 16'd2);
            check("star_grant_who", ram_addr, exp_if ? 16'h0300 : 16'h0010);
            check("star_cnt", 16'(starve_cnt), exp_starve[g]);
            ram_rdata = 16'h1000 + 16'(g);
            step();
            if (exp_if) begin
                check("star_if_done", 16'(if_done), 16'd1);
                check("star_if_rdata", if_rdata, 16'h1000 + 16'(g));
                if_req = 1'b0;
            end else begin
                check("star_mem_done", 16'(mem_done), 16'd1);
                check("star_mem_rdata", mem_rdata, 16'h1000 + 16'(g));
                if (g == 4) mem_req = 1'b0;
            end
        end
        step();

        // asynchronous reset during a MEM access
        mem_req   = 1'b1;
        mem_ctrl  = 2'b10;
        mem_addr  = 16'h0400;
        mem_wdata = 16'h1111;
        step();
        check("rstmid_grant_ctrl", 16'(ram_ctrl), 16'd2);
        #2 rst = 1'b0;
        #1;
        check("rstmid_async_ctrl", 16'(ram_ctrl), 16'd0);
        check("rstmid_async_addr", ram_addr, 16'h0);
        check("rstmid_async_state", 16'(fsm_state), 16'd0);
        @(posedge clk);
        #1;
        check("rstmid_no_done", 16'(mem_done), 16'd0);
        rst = 1'b1;
        step();
        check("rstmid_regrant_ctrl", 16'(ram_ctrl), 16'd2);
        check("rstmid_regrant_addr", ram_addr, 16'h0400);
        check("rstmid_regrant_wdata", ram_wdata, 16'h1111);
        step();
        check("rstmid_done", 16'(mem_done), 16'd1);
        mem_req = 1'b0;
        step();

        // invalid MEM control is not a request
        mem_req  = 1'b1;
        mem_ctrl = 2'b11;
        mem_addr = 16'h0500;
        for (int i = 0; i < 4; i++) begin
            step();
            check("inv_state", 16'(fsm_state), 16'd0);
            check("inv_ctrl", 16'(ram_ctrl), 16'd0);
            check("inv_stall", 16'(mem_stall), 16'd1);
            check("inv_no_done", 16'(mem_done), 16'd0);
        end
        mem_ctrl = 2'b01;
        step();
        check("inv_fix_ctrl", 16'(ram_ctrl), 16'd1);
        check("inv_fix_addr", ram_addr, 16'h0500);
        ram_rdata = 16'h7777;
        step();
        check("inv_fix_done", 16'(mem_done), 16'd1);
        check("inv_fix_rdata", mem_rdata, 16'h7777);
        mem_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive MEM grants tolerated while IF waits (range 1..3).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request; held high until if_done.
REQ-005 SHALL have port if_addr  input  16  instruction-fetch address.
REQ-006 SHALL have port mem_req  input  1  MEM-stage request; held high until mem_done.
REQ-007 SHALL have port mem_ctrl  input  2  MEM-stage operation: 01 read, 10 write, 00/11 none.
REQ-008 SHALL have port mem_addr  input  16  MEM-stage address.
REQ-009 SHALL have port mem_wdata  input  16  MEM-stage store data.
REQ-010 SHALL have port ram_rdata  input  16  data from memory, combinationally valid while ram_addr/ram_ctrl are held.
REQ-011 SHALL have port ram_addr  output  16  registered address to memory.
REQ-012 SHALL have port ram_ctrl  output  2  registered control to memory, same encoding as mem_ctrl.
REQ-013 SHALL have port ram_wdata  output  16  registered store data to memory.
REQ-014 SHALL have port if_rdata / mem_rdata  output  16 each  registered read data returned to each requester.
REQ-015 SHALL have port if_done / mem_done  output  1 each  one-cycle completion pulses.
REQ-016 SHALL have port if_stall / mem_stall  output  1 each  combinational: req & ~done.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_MEM.
REQ-018 SHALL treat mem_req with mem_ctrl of 00 or 11 as no request: no access issued and mem_done never pulses.
REQ-019 In IDLE at posedge, SHALL grant a valid MEM request before IF, unless starve_cnt == STARVE_LIMIT and if_req is high, in which case SHALL grant IF.
REQ-020 On grant, SHALL register the granted address, ctrl (01 for IF), and wdata (mem_wdata for MEM, 0 for IF) onto the ram_* outputs, then enter BUSY_IF or BUSY_MEM.
REQ-021 In BUSY_x at the next posedge, SHALL capture ram_rdata into x_rdata (reads only; writes leave x_rdata unchanged), pulse x_done for exactly one cycle, drive ram_ctrl to 00, and return to IDLE.
REQ-022 SHALL have a latency of 2 posedges from a request sampled in IDLE to its done pulse, with a minimum of 3 cycles between successive grants.
REQ-023 SHALL keep starve_cnt, 2 bits: increment (saturating at STARVE_LIMIT) on each MEM grant made while if_req is high; clear on each IF grant; hold otherwise.
REQ-024 SHALL not sample request or address changes while BUSY; ram_* outputs SHALL stay stable for the whole access.
REQ-025 SHALL not retain a request dropped before its grant; nothing is queued.
REQ-026 SHALL ignore the done requester's still-high req in the done cycle; arbitration resumes in IDLE at the following posedge.

Reset
REQ-027 When rst is low, SHALL immediately force: state IDLE; ram_addr, ram_wdata, if_rdata, mem_rdata, and starve_cnt to 0; ram_ctrl to 00; if_done and mem_done to 0. This applies mid-access, and the aborted access produces no done pulse.
REQ-028 The first grant after rst rises SHALL occur at the first posedge with rst high.

Verification
REQ-029 IF read alone: if_addr=0x0040, ram_rdata=0x1234 -> ram_addr=0x0040, ram_ctrl=01 for one cycle; if_rdata=0x1234 and if_done pulse at the 2nd posedge.
REQ-030 Simultaneous requests: if_req=1, MEM write to 0x0100 of 0xBEEF -> MEM served first (ram_ctrl=10, ram_wdata=0xBEEF); IF granted at the next IDLE; if_stall high throughout.
REQ-031 Starvation: if_req held with 4 back-to-back MEM reads (STARVE_LIMIT=3) -> grant order MEM, MEM, MEM, IF, MEM; starve_cnt reads 3 before the IF grant and 0 after it.
REQ-032 Reset during BUSY_MEM: rst low mid-access -> ram_ctrl=00 asynchronously, no mem_done pulse; after release, a pending mem_req is re-granted at the first posedge.
REQ-033 Invalid ctrl: mem_req=1 with mem_ctrl=11 and if_req=0 -> FSM stays IDLE, ram_ctrl=00, mem_stall=1 until the requester changes the request.
